// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file block and its readers.
// Holds the default register-file geometry, the dump-reader state encoding
// and a helper that sizes hold counters.
package regfile_pkg;

    localparam int REGFILE_ADDR_W = 2;
    localparam int REGFILE_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

    // Width of a down-counter that must hold values 0 .. hold-1.
    function automatic int hold_cnt_w(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_hold_timer.sv
// hold_timer: loadable down-counter with a zero flag.
// Load wins over decrement; the count saturates at zero so an idle
// decrement request never wraps.
module hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Count register: load, otherwise decrement toward zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: on a start pulse, walks every register address through
// one regfile read port, captures each value and holds it on the display
// outputs for HOLD_CYCLES cycles, then pulses done.
//
// Optional build macro REGFILE_DUMP_LOOP_EN: when defined the scan repeats
// indefinitely (DONE returns to SETUP at address 0, disp_valid stays high),
// and a start pulse while busy stops the scan and returns to IDLE without a
// done pulse. Undefined: single-shot scan, start while busy is ignored.
//
// Request handshake: start is a one-cycle request accepted only when busy=0
// (state IDLE); busy rises the edge after acceptance and stays high through
// SETUP, HOLD and DONE; done is a one-cycle completion pulse while busy=1.
// state_dbg exposes the FSM state for observation.
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int ADDR_W      = REGFILE_ADDR_W,
    parameter int DATA_W      = REGFILE_DATA_W,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy,
    output logic              done,
    output dump_state_t       state_dbg
);

    localparam int                NUM_REGS  = 2 ** ADDR_W;
    localparam int                CNT_W     = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    dump_state_t      state;
    logic             tmr_load;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_zero;
    logic             stop_req;

    // Timer is reloaded in SETUP and counts down through HOLD.
    always_comb begin
        tmr_load = (state == SETUP);
        tmr_dec  = (state == HOLD);
        stop_req = LOOP_EN && start && (state != IDLE);
    end

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (HOLD_LOAD),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Reader FSM with registered address, capture and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_addr    <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop_req) begin
                // Looping build only: a start while scanning aborts the scan.
                state      <= IDLE;
                busy       <= 1'b0;
                disp_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= SETUP;
                            rd_addr <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    SETUP: begin
                        // rd_addr has been stable for a full cycle: capture.
                        disp_data  <= rd_data;
                        disp_addr  <= rd_addr;
                        disp_valid <= 1'b1;
                        state      <= HOLD;
                    end
                    HOLD: begin
                        if (tmr_zero) begin
                            if (rd_addr == LAST_ADDR) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                rd_addr <= rd_addr + 1'b1;
                                state   <= SETUP;
                            end
                        end
                    end
                    DONE: begin
                        if (LOOP_EN) begin
                            state   <= SETUP;
                            rd_addr <= '0;
                        end else begin
                            // disp_addr/disp_data keep the last captured value.
                            state      <= IDLE;
                            busy       <= 1'b0;
                            disp_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Testbench for regfile_dump_reader with HOLD_CYCLES=4 and a 4x4 regfile
// model preloaded with R0=0x3, R1=0xA, R2=0x0, R3=0xF.
// Scan timing is checked against a table of {cycle offset, expected outputs}
// rows relative to the edge k that samples start.
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    localparam int HOLD = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [1:0]  rd_addr;
    logic [3:0]  rd_data;
    logic [1:0]  disp_addr;
    logic [3:0]  disp_data;
    logic        disp_valid;
    logic        busy;
    logic        done;
    dump_state_t state_dbg;

    logic [3:0] regs [4];
    assign rd_data = regs[rd_addr];

    regfile_dump_reader #(
        .ADDR_W      (2),
        .DATA_W      (4),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         n;
        logic       busy;
        logic       done;
        logic       valid;
        logic [1:0] addr;
        logic [3:0] data;
        logic [1:0] rda;
        bit         chk_disp;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    // ---------------- driver tasks ----------------
    // One full single-shot scan. extra_start: second start sampled at k+3.
    // rewrite: regfile writes R1=0x5 just after edge k+7 (mid-HOLD of R1).
    // r1_exp: the R1 value this scan is expected to capture.
    task automatic do_scan(input bit extra_start, input bit rewrite, input logic [3:0] r1_exp);
        int dcnt;
        logic [3:0] exp_data;
        dcnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);  // edge k
        for (int n = 0; n <= 22; n++) begin
            @(negedge clk);
            if (done) dcnt++;
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].n == n) begin
                    exp_data = (tbl[i].addr == 2'd1) ? r1_exp : tbl[i].data;
                    chk($sformatf("busy@k+%0d", n), 32'(busy), 32'(tbl[i].busy));
                    chk($sformatf("done@k+%0d", n), 32'(done), 32'(tbl[i].done));
                    chk($sformatf("valid@k+%0d", n), 32'(disp_valid), 32'(tbl[i].valid));
                    chk($sformatf("rd_addr@k+%0d", n), 32'(rd_addr), 32'(tbl[i].rda));
                    if (tbl[i].chk_disp) begin
                        chk($sformatf("disp_addr@k+%0d", n), 32'(disp_addr), 32'(tbl[i].addr));
                        chk($sformatf("disp_data@k+%0d", n), 32'(disp_data), 32'(exp_data));
                    end
                end
            end
            start = extra_start && (n == 2);
            if (rewrite && n == 7) regs[1] = 4'h5;
            @(posedge clk);
        end
        chk("done_count", 32'(dcnt), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_disp_addr"}, 32'(disp_addr), 32'd0);
        chk({tag, "_disp_data"}, 32'(disp_data), 32'd0);
        chk({tag, "_valid"}, 32'(disp_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

`ifdef REGFILE_DUMP_LOOP_EN
    task automatic do_loop_scan();
        int dcnt;
        dcnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);  // edge k
        for (int n = 0; n <= 30; n++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (n == 1)  chk("loop_data@k+1", 32'(disp_data), 32'h3);
            if (n == 20) chk("loop_done@k+20", 32'(done), 32'd1);
            if (n == 21) begin
                chk("loop_rd_addr@k+21", 32'(rd_addr), 32'd0);
                chk("loop_valid@k+21", 32'(disp_valid), 32'd1);
                chk("loop_busy@k+21", 32'(busy), 32'd1);
            end
            if (n == 22) chk("loop_data@k+22", 32'(disp_data), 32'h3);
            if (n == 26) begin
                chk("loop_stop_state@k+26", 32'(state_dbg), 32'(IDLE));
                chk("loop_stop_valid@k+26", 32'(disp_valid), 32'd0);
                chk("loop_stop_busy@k+26", 32'(busy), 32'd0);
            end
            start = (n == 25);
            @(posedge clk);
        end
        chk("loop_done_count_stopped", 32'(dcnt), 32'd1);
        // Second run without a stop: done at k+20 and k+41.
        dcnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 42; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dcnt++;
            if (n == 20) chk("loop2_done@k+20", 32'(done), 32'd1);
            if (n == 41) chk("loop2_done@k+41", 32'(done), 32'd1);
            if (n == 42) chk("loop2_rd_addr@k+42", 32'(rd_addr), 32'd0);
            @(posedge clk);
        end
        chk("loop2_done_count", 32'(dcnt), 32'd2);
    endtask
`endif

    // ---------------- test sequence ----------------
    initial begin
        int dcnt;
        regs[0] = 4'h3; regs[1] = 4'hA; regs[2] = 4'h0; regs[3] = 4'hF;

        //            n   busy  done  valid addr   data   rd_addr chk_disp
        tbl[0]  = '{0,  1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 1'b0};
        tbl[1]  = '{1,  1'b1, 1'b0, 1'b1, 2'd0, 4'h3, 2'd0, 1'b1};
        tbl[2]  = '{5,  1'b1, 1'b0, 1'b1, 2'd0, 4'h3, 2'd1, 1'b1};
        tbl[3]  = '{6,  1'b1, 1'b0, 1'b1, 2'd1, 4'hA, 2'd1, 1'b1};
        tbl[4]  = '{10, 1'b1, 1'b0, 1'b1, 2'd1, 4'hA, 2'd2, 1'b1};
        tbl[5]  = '{11, 1'b1, 1'b0, 1'b1, 2'd2, 4'h0, 2'd2, 1'b1};
        tbl[6]  = '{16, 1'b1, 1'b0, 1'b1, 2'd3, 4'hF, 2'd3, 1'b1};
        tbl[7]  = '{19, 1'b1, 1'b0, 1'b1, 2'd3, 4'hF, 2'd3, 1'b1};
        tbl[8]  = '{20, 1'b1, 1'b1, 1'b1, 2'd3, 4'hF, 2'd3, 1'b1};
        tbl[9]  = '{21, 1'b0, 1'b0, 1'b0, 2'd3, 4'hF, 2'd3, 1'b1};
        tbl[10] = '{22, 1'b0, 1'b0, 1'b0, 2'd3, 4'hF, 2'd3, 1'b1};

        // Reset, then idle for 10 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("idle_done_count", 32'(dcnt), 32'd0);
        check_all_zero("idle");

`ifdef REGFILE_DUMP_LOOP_EN
        do_loop_scan();
`else
        // Plain scan.
        do_scan(1'b0, 1'b0, 4'hA);
        // Start during scan ignored; R1 rewritten mid-HOLD of R1.
        do_scan(1'b1, 1'b1, 4'hA);
        // Rerun picks up the new R1.
        do_scan(1'b0, 1'b0, 4'h5);
`endif

        // Asynchronous reset mid-scan, between edges after k+9.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);  // edge k
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);  // edge k+9
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_rst");

`ifndef REGFILE_DUMP_LOOP_EN
        // Restart after reset scans from address 0.
        do_scan(1'b0, 1'b0, 4'h5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Reader-side companion to the 4x4 register file, which the board writes from switches.
- On a start pulse, walks every register address through one regfile read port in turn. Captures each value and presents it on display outputs for a programmable hold time, then signals completion.
- Sits between the debounced button path and the LED driver. Gives visibility of the whole register file without manual address switching.

Parameters:
- ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W.
- DATA_W, 4, register data width.
- HOLD_CYCLES, 100000000, clk cycles each captured value is held on the display; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  single-cycle request pulse (debounced, edge-detected upstream).
- rd_addr  output  ADDR_W  read address driven to the regfile read port.
- rd_data  input  DATA_W  combinational read data returned for rd_addr.
- disp_addr  output  ADDR_W  address of the value currently displayed.
- disp_data  output  DATA_W  captured register value.
- disp_valid  output  1  disp_addr/disp_data are meaningful.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when the scan completes.

Behaviour:
- Reset, asynchronous: state=IDLE; rd_addr=0, disp_addr=0, disp_data=0, disp_valid=0, busy=0, done=0; hold counter=0.
- States:
  - IDLE: busy=0. On start=1, go to SETUP with rd_addr=0.
  - SETUP: one cycle with rd_addr stable. At its closing edge:
    - disp_data<=rd_data, disp_addr<=rd_addr, disp_valid<=1;
    - hold counter<=HOLD_CYCLES-1;
    - go to HOLD.
  - HOLD: counter decrements each cycle. When counter==0:
    - if rd_addr==NUM_REGS-1, go to DONE;
    - else rd_addr<=rd_addr+1 and go to SETUP.
  - DONE: one cycle. done=1, busy=1. Next state IDLE; disp_valid cleared on exit; disp_data/disp_addr keep the last value.
- busy=1 in SETUP, HOLD and DONE.
- Timing, start sampled at edge k:
  - busy=1 and rd_addr=0 after edge k.
  - First capture at edge k+1.
  - Each register occupies 1+HOLD_CYCLES cycles.
  - DONE entered at edge k+NUM_REGS*(1+HOLD_CYCLES); IDLE one cycle later.
- start while busy: ignored.
- start in the same cycle DONE exits: ignored; a new scan needs start while in IDLE.
- rd_data is sampled only at the SETUP edge. Regfile writes during HOLD do not alter disp_data until that address is read again.
- Address wrap: rd_addr never increments past NUM_REGS-1; it holds that value in DONE and is reset to 0 on the next start.
- Reset mid-scan: immediate return to IDLE with reset values; no done pulse.
- HOLD_CYCLES=1: HOLD lasts exactly one cycle (counter loads 0).

Optional Feature:
- Macro REGFILE_DUMP_LOOP_EN.
- Defined:
  - After HOLD of the last address, go to DONE (done pulse). Then return to SETUP with rd_addr=0 instead of IDLE; disp_valid stays 1.
  - Scanning repeats indefinitely.
  - A start pulse while busy stops the scan: transition to IDLE at the next edge, disp_valid=0, no done pulse.
- Undefined: single-shot behaviour as above; start while busy is ignored.

Decomposition:
- Shared package regfile_pkg: REGFILE_ADDR_W=2, REGFILE_DATA_W=4, and the state enum type dump_state_t {IDLE, SETUP, HOLD, DONE}.
- One natural sub-module: hold_timer (load value, decrement, zero flag), reusable by display blocks.
- Reader FSM and capture registers stay in regfile_dump_reader.

Test Plan (HOLD_CYCLES=4, regfile model preloaded R0=0x3, R1=0xA, R2=0x0, R3=0xF):
- Reset then idle 10 cycles -> all outputs 0; busy=0; done never asserted.
- Start pulse at edge k -> disp_valid=1 and disp_data=0x3, disp_addr=0 from edge k+1. Subsequent captures:
  - 0xA at k+6;
  - 0x0 at k+11;
  - 0xF at k+16.
  - done=1 only during cycle after edge k+20; busy=0 after edge k+21.
- Second start pulse at k+3 during scan -> ignored; scan timing identical to the previous case; exactly one done pulse.
- Model rewrites R1 to 0x5 at k+7, mid-HOLD of R1 -> disp_data stays 0xA until the R2 capture. A rerun then shows R1=0x5.
- rst asserted asynchronously at k+9, between edges -> outputs zero before the next edge. A start after release restarts from address 0.
- With REGFILE_DUMP_LOOP_EN:
  - done pulses at k+20 and k+41;
  - rd_addr returns to 0 after each;
  - a start pulse at k+25 forces IDLE at k+26 with disp_valid=0.
